npu_seq_ctrl: RTL
=================

# npu_seq_ctrl

Parametrised successor to the NPU state machine: sequences one NPU invocation through configure, input load, fixed-latency compute and output drain. It gates the scheduler's FIFO read/write strobes against FIFO empty/full and counts inputs and outputs against programmed totals. It reuses a valid configuration for back-to-back invocations without re-entering CONFIG. Sits between the NPU scheduler and the config/input/output FIFOs.

## Interface
- DATA_W, 16, width of npu_state_data_in
- CNT_W, 8, width of input/output count registers (CNT_W ≤ DATA_W)
- LAT, 4, compute latency in cycles (≥1)

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- npu_state_data_in  in  DATA_W  config word; low CNT_W bits used
- npu_state_input_reg_enable  in  1  load input count N_IN
- npu_state_output_reg_enable  in  1  load output count N_OUT
- npu_config_fifo_empty  in  1  config FIFO empty
- npu_input_fifo_empty  in  1  input FIFO empty
- npu_sched_input_fifo_read_en  in  1  scheduler read request
- npu_output_fifo_full  in  1  output FIFO full
- npu_sched_output_fifo_write_en  in  1  scheduler write request
- npu_input_fifo_read_en  out  1  gated read strobe
- npu_output_fifo_write_en  out  1  gated write strobe
- npu_state_idle / _config / _load / _compute / _drain / _stall  out  1 each  one-hot state flags
- npu_inputs_done  out  1  one-cycle pulse, all inputs read
- npu_outputs_done  out  1  one-cycle pulse, all outputs written
- npu_cfg_err  out  1  one-cycle pulse, zero count programmed
- npu_in_count  out  CNT_W  inputs read this invocation
- npu_out_count  out  CNT_W  outputs written this invocation
- npu_stall_cycles  out  16  stall cycle counter (see Configuration)

## Operation
- States: IDLE, CONFIG, LOAD, COMPUTE, DRAIN, STALL; state register with one-hot flags decoded from it.
- IDLE: !config_fifo_empty -> CONFIG (priority); else cfg_valid & !input_fifo_empty -> LOAD.
- CONFIG: input_reg_enable loads N_IN, output_reg_enable loads N_OUT; both in one cycle load both. Enables ignored outside CONFIG. Exit when config_fifo_empty: both counts nonzero -> LOAD, cfg_valid=1; else -> IDLE, cfg_valid=0, cfg_err pulses.
- LOAD: input_fifo_read_en = sched_read & !input_fifo_empty. Each read increments in_count. Read taking in_count to N_IN -> COMPUTE. sched_read & input_fifo_empty -> STALL, no read that cycle.
- COMPUTE: exactly LAT cycles, then DRAIN; both strobes held 0.
- DRAIN: output_fifo_write_en = sched_write & !output_fifo_full; each write increments out_count. Write taking out_count to N_OUT -> next state by IDLE rules (config priority, else LOAD if input non-empty, else IDLE). sched_write & full -> STALL.
- STALL: remembers return state (LOAD or DRAIN); returns when blocking condition clears (input non-empty / output not full). Strobes 0 in STALL.
- Counts clear on entry to LOAD; hold values through IDLE.

## Timing
- Reset (RST_N low, asynchronous, also mid-operation): state IDLE, state_idle=1, all other outputs 0, N_IN=N_OUT=0, cfg_valid=0, counters 0.
- Read/write strobes combinational from state and inputs (same-cycle gating).
- State flags, counts, done/err pulses registered: inputs_done high during first COMPUTE cycle; outputs_done high in first cycle after last write; cfg_err high in first IDLE cycle after failed CONFIG.
- Last read to first DRAIN cycle: LAT+1 cycles.
- No counter wraps: transitions occur on reaching N_IN/N_OUT (max 2^CNT_W-1).

## Configuration
- NPU_SEQ_PERF_EN defined: npu_stall_cycles increments every cycle in STALL, saturates at 16'hFFFF, clears only on reset.
- Undefined: counter logic omitted, npu_stall_cycles tied to 0.

## Test plan
- Reset, config_fifo non-empty, write N_IN=4, N_OUT=2, config empty -> CONFIG then LOAD; state_load=1.
- 4 reads with input non-empty -> in_count 1..4, inputs_done one cycle, COMPUTE exactly LAT=4 cycles, then DRAIN.
- Input empty during read request after 2 reads -> STALL, read_en=0; non-empty -> LOAD, completes at 4 reads; with PERF_EN stall_cycles equals stalled cycles.
- Output full during write request -> STALL, write_en=0; clear -> DRAIN, 2 writes, outputs_done pulse, input non-empty -> LOAD reusing N_IN=4.
- CONFIG with N_OUT=0 -> cfg_err pulse, IDLE, input non-empty does not start LOAD.
- RST_N low mid-DRAIN -> immediate IDLE, counts 0, cfg_valid cleared.

Source files
------------

// File: rtl/npu_seq_ctrl.sv
// NPU invocation sequencer: configure, input load, fixed-latency compute, output drain.
// Optional stall-cycle performance counter enabled by defining NPU_SEQ_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for config words or a new invocation with a valid config
// CONFIG  | loading N_IN / N_OUT from the config word
// LOAD    | reading N_IN inputs through the gated read strobe
// COMPUTE | fixed LAT-cycle compute window, strobes held low
// DRAIN   | writing N_OUT outputs through the gated write strobe
// STALL   | blocked on empty input / full output, returns to LOAD or DRAIN
module npu_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  parameter int LAT    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] npu_state_data_in,
  input  logic              npu_state_input_reg_enable,
  input  logic              npu_state_output_reg_enable,
  input  logic              npu_config_fifo_empty,
  input  logic              npu_input_fifo_empty,
  input  logic              npu_sched_input_fifo_read_en,
  input  logic              npu_output_fifo_full,
  input  logic              npu_sched_output_fifo_write_en,
  output logic              npu_input_fifo_read_en,
  output logic              npu_output_fifo_write_en,
  output logic              npu_state_idle,
  output logic              npu_state_config,
  output logic              npu_state_load,
  output logic              npu_state_compute,
  output logic              npu_state_drain,
  output logic              npu_state_stall,
  output logic              npu_inputs_done,
  output logic              npu_outputs_done,
  output logic              npu_cfg_err,
  output logic [CNT_W-1:0]  npu_in_count,
  output logic [CNT_W-1:0]  npu_out_count,
  output logic [15:0]       npu_stall_cycles
);

  localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_LOAD, S_COMPUTE, S_DRAIN, S_STALL
  } state_t;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [CNT_W-1:0]   n_in_q, n_in_d;
  logic [CNT_W-1:0]   n_out_q, n_out_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               in_done_q, in_done_d;
  logic               out_done_q, out_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               rd_en, wr_en;
  logic               unused_data;

  // Only the low CNT_W bits of the config word carry a count.
  assign unused_data = ^npu_state_data_in;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      ret_q       <= S_LOAD;
      cfg_valid_q <= 1'b0;
      n_in_q      <= '0;
      n_out_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      lat_q       <= '0;
      in_done_q   <= 1'b0;
      out_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cfg_valid_q <= cfg_valid_d;
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      lat_q       <= lat_d;
      in_done_q   <= in_done_d;
      out_done_q  <= out_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cfg_valid_d = cfg_valid_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    lat_d       = lat_q;
    in_done_d   = 1'b0;
    out_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!npu_config_fifo_empty) begin
          state_d = S_CONFIG;
        end else if (cfg_valid_q && !npu_input_fifo_empty) begin
          state_d   = S_LOAD;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_CONFIG: begin
        if (npu_state_input_reg_enable)  n_in_d  = npu_state_data_in[CNT_W-1:0];
        if (npu_state_output_reg_enable) n_out_d = npu_state_data_in[CNT_W-1:0];
        // Validity is judged on the counts as they stand after this cycle's loads.
        if (npu_config_fifo_empty) begin
          if ((n_in_d != '0) && (n_out_d != '0)) begin
            state_d     = S_LOAD;
            cfg_valid_d = 1'b1;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
          end else begin
            state_d     = S_IDLE;
            cfg_valid_d = 1'b0;
            cfg_err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rd_en = npu_sched_input_fifo_read_en && !npu_input_fifo_empty;
        if (rd_en) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_d == n_in_q) begin
            state_d   = S_COMPUTE;
            in_done_d = 1'b1;
            lat_d     = LAT_W'(LAT - 1);
          end
        end else if (npu_sched_input_fifo_read_en) begin
          state_d = S_STALL;
          ret_d   = S_LOAD;
        end
      end
      S_COMPUTE: begin
        if (lat_q == '0) state_d = S_DRAIN;
        else             lat_d   = lat_q - 1'b1;
      end
      S_DRAIN: begin
        wr_en = npu_sched_output_fifo_write_en && !npu_output_fifo_full;
        if (wr_en) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_d == n_out_q) begin
            out_done_d = 1'b1;
            if (!npu_config_fifo_empty) begin
              state_d = S_CONFIG;
            end else if (cfg_valid_q && !npu_input_fifo_empty) begin
              state_d   = S_LOAD;
              in_cnt_d  = '0;
              out_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (npu_sched_output_fifo_write_en) begin
          state_d = S_STALL;
          ret_d   = S_DRAIN;
        end
      end
      S_STALL: begin
        if (ret_q == S_LOAD) begin
          if (!npu_input_fifo_empty) state_d = S_LOAD;
        end else if (!npu_output_fifo_full) begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign npu_input_fifo_read_en   = rd_en;
  assign npu_output_fifo_write_en = wr_en;
  assign npu_state_idle    = (state_q == S_IDLE);
  assign npu_state_config  = (state_q == S_CONFIG);
  assign npu_state_load    = (state_q == S_LOAD);
  assign npu_state_compute = (state_q == S_COMPUTE);
  assign npu_state_drain   = (state_q == S_DRAIN);
  assign npu_state_stall   = (state_q == S_STALL);
  assign npu_inputs_done   = in_done_q;
  assign npu_outputs_done  = out_done_q;
  assign npu_cfg_err       = cfg_err_q;
  assign npu_in_count      = in_cnt_q;
  assign npu_out_count     = out_cnt_q;

`ifdef NPU_SEQ_PERF_EN
  logic [15:0] stall_cyc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                           stall_cyc_q <= '0;
    else if (state_q == S_STALL && stall_cyc_q != 16'hFFFF) stall_cyc_q <= stall_cyc_q + 1'b1;
  end

  assign npu_stall_cycles = stall_cyc_q;
`else
  assign npu_stall_cycles = '0;
`endif

endmodule
